nonrestoring_divider: RTL
=========================

NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: rst is sampled only on the rising edge of clk.
REQ-002 Parameter WIDTH, default 32: operand, quotient and remainder width.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port start, input, 1: request a division; sampled only in IDLE.
REQ-006 Port dividend, input, WIDTH: unsigned dividend, captured when start is accepted.
REQ-007 Port divisor, input, WIDTH: unsigned divisor, captured when start is accepted.
REQ-008 Port busy, output, 1: high in every state other than IDLE.
REQ-009 Port done, output, 1: single-cycle pulse marking valid results.
REQ-010 Port quotient, output, WIDTH: registered quotient result.
REQ-011 Port remainder, output, WIDTH: registered remainder result.
REQ-012 Port div_by_zero, output, 1: registered flag, valid with done.

Function
REQ-013 States SHALL be IDLE, ITER, CORRECT and FINISH.
REQ-014 IDLE with start=1 SHALL capture the operands on the same edge and clear partial remainder P (WIDTH+1 bits, signed).
REQ-015 From IDLE with start=1 and divisor!=0, the next state SHALL be ITER and the step counter SHALL load WIDTH-1.
REQ-016 From IDLE with start=1 and divisor==0, the next state SHALL be FINISH with quotient=all ones, remainder=dividend and div_by_zero=1.
REQ-017 Each ITER edge SHALL shift {P,A} left by 1, then form P=P-D if old P[WIDTH]==0 or P=P+D otherwise, then set the new A[0]=~P[WIDTH].
REQ-018 Each add/sub step SHALL be one (WIDTH+1)-bit adder with operand B = {0,D} XOR sub and carry-in = sub, where sub=~old P[WIDTH].
REQ-019 ITER SHALL run exactly WIDTH edges and, when the counter reaches 0, SHALL move to CORRECT.
REQ-020 CORRECT SHALL add D to P if P[WIDTH]==1, then latch quotient=A, remainder=P[WIDTH-1:0] and div_by_zero=0, and move to FINISH.
REQ-021 FINISH SHALL drive done=1 for exactly one cycle, then return to IDLE.
REQ-022 Latency SHALL be WIDTH+2 cycles from accepted start to done (34 for WIDTH=32), or 1 cycle for divide-by-zero.
REQ-023 A start asserted while busy=1 SHALL be ignored, with no effect on state or operands.
REQ-024 A start asserted in the FINISH cycle SHALL be ignored, so a new division is accepted one cycle after the done pulse at the earliest.
REQ-025 quotient, remainder and div_by_zero SHALL hold their last values until the next result is latched.
REQ-026 Operand inputs SHALL be don't-care except on the accept edge.

Reset
REQ-027 rst=1 SHALL, on the clock edge, force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0 and P=0, with priority over start.
REQ-028 rst asserted mid-operation SHALL abort the division with no done pulse, and the next accepted start SHALL produce a correct result.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the WIDTH default and the iteration count constant.
REQ-030 The (WIDTH+1)-bit add/sub SHALL be one sub-module, addsub_n, with inputs a, b and sub, and outputs sum and cout; b SHALL be XOR-ed with sub and sub SHALL be used as carry-in.
REQ-031 The top level SHALL contain only the FSM, the counter and the P/A/D registers.

Verification
REQ-032 Scenario: 100 / 7 -> done 34 cycles after start, quotient=14, remainder=2, div_by_zero=0.
REQ-033 Scenario: 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0; 0x80000000 / 0xFFFFFFFF -> quotient=0, remainder=0x80000000.
REQ-034 Scenario: 5 / 0 -> done 1 cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-035 Scenario: 3 / 10 -> quotient=0, remainder=3; then start for 1000 / 10 pulsed at cycle 5 of the run -> ignored, results still 0/3.
REQ-036 Scenario: rst at cycle 10 of 1000 / 33 -> no done, all outputs 0, busy=0; new 1000 / 33 -> quotient=30, remainder=10.
REQ-037 Scenario: 10,000 random operand pairs, 5% with divisor 0 -> every result matches the golden model quotient/remainder, every done is one cycle wide, and every latency matches REQ-022.

Source files
------------

// File: rtl/nonrestoring_divider_pkg.sv
// Shared types and constants for the nonrestoring divider.
// Imported by the top level and the add/sub datapath.
package nonrestoring_divider_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int ITER_COUNT = DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CORRECT,
    FINISH
  } state_t;

endpackage

// File: rtl/nonrestoring_divider_addsub.sv
// N-bit adder/subtractor: sum = a + (b ^ sub) + sub.
// One carry chain serves both the add and the subtract step.
module addsub_n
  import nonrestoring_divider_pkg::*;
#(
  parameter int N = DEF_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] b_x;

  assign b_x = b ^ {N{sub}};

  assign {cout, sum} = {1'b0, a}
                     + {1'b0, b_x}
                     + {{N{1'b0}}, sub};

endmodule

// File: rtl/nonrestoring_divider.sv
// Multi-cycle unsigned nonrestoring divider.
// One quotient bit per cycle, then a single remainder fix-up.
module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   sum;
  logic             as_sub;
  logic             cout_unused;

  // CORRECT reuses the adder with sub=0 to add D back
  assign as_a   = (state == CORRECT) ? p
                : {p[WIDTH-1:0], a[WIDTH-1]};
  assign as_sub = (state == ITER) & ~p[WIDTH];

  addsub_n #(.N(WIDTH + 1)) u_addsub (
    .a    (as_a),
    .b    ({1'b0, d}),
    .sub  (as_sub),
    .sum  (sum),
    .cout (cout_unused)
  );

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (divisor == '0) ? FINISH : ITER;
        end
      end
      ITER: begin
        if (cnt == '0) begin
          state_nx = CORRECT;
        end
      end
      CORRECT: state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      a           <= '0;
      d           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            p   <= '0;
            a   <= dividend;
            d   <= divisor;
            cnt <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        ITER: begin
          p <= sum;
          a <= {a[WIDTH-2:0], ~sum[WIDTH]};
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        CORRECT: begin
          if (p[WIDTH]) begin
            p <= sum;
          end
          quotient    <= a;
          remainder   <= p[WIDTH] ? sum[WIDTH-1:0]
                                  : p[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
